mult_seq_param: RTL

Parametrised iterative shift-add multiplier: the generalised successor to the fixed 32-bit sequential multiplier in the pipeline's execute stage. It adds a configurable operand width and run-time signed/unsigned selection. It also provides an explicit IDLE/RUN/DONE controller with busy, a one-cycle done pulse and cancel, plus a registered product that holds until the next operation completes. The EX-stage controller stalls on `mult_busy` and writes HI/LO on `mult_end`.

---
 rtl/mult_seq_param.sv | 96 +++++++++
 1 files changed

// File: rtl/mult_seq_param.sv
// Iterative shift-add multiplier with run-time signed/unsigned selection.
// One partial product per cycle; terminates early once the remaining
// multiplier bits are all zero. Signed operands are multiplied as
// magnitudes and the sign is applied to the final accumulator.
//
// Handshake: mult_begin is taken whenever the controller is not in RUN
// (IDLE or DONE). mult_busy is high for every RUN cycle. mult_end is a
// one-cycle pulse in DONE, when product holds the new result. mult_cancel
// acts only in RUN and returns to IDLE without touching product.
module mult_seq_param #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mult_begin,
  input  logic               mult_signed,
  input  logic [WIDTH-1:0]   mult_op1,
  input  logic [WIDTH-1:0]   mult_op2,
  input  logic               mult_cancel,
  output logic [2*WIDTH-1:0] product,
  output logic               mult_busy,
  output logic               mult_end,
  output logic [1:0]         state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH-1:0]   ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_P = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]         state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic               neg;

  logic [WIDTH-1:0]   abs_op1;
  logic [WIDTH-1:0]   abs_op2;
  logic [2*WIDTH-1:0] result;

  // Operand magnitudes (mod 2^WIDTH, so the most-negative value maps to
  // 2^(WIDTH-1)) and the sign-corrected final result.
  always_comb begin
    abs_op1 = mult_op1;
    abs_op2 = mult_op2;
    if (mult_signed && mult_op1[WIDTH-1]) abs_op1 = ~mult_op1 + ONE_W;
    if (mult_signed && mult_op2[WIDTH-1]) abs_op2 = ~mult_op2 + ONE_W;
    result = neg ? (~acc + ONE_P) : acc;
  end

  // Controller and datapath: capture, iterate, terminate, cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (mult_cancel) begin
            state <= S_IDLE;
          end else if (mplier == '0) begin
            product <= result;
            state   <= S_DONE;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
        end
        S_IDLE, S_DONE: begin
          if (mult_begin) begin
            mcand  <= {{WIDTH{1'b0}}, abs_op1};
            mplier <= abs_op2;
            acc    <= '0;
            neg    <= mult_signed & (mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1]);
            state  <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mult_busy = (state == S_RUN);
  assign mult_end  = (state == S_DONE);
  assign state_dbg = state;

endmodule
